// File: rtl/zevensegment_scan_axil.sv
// AXI4-Lite seven-segment scanner: hex/raw digits, dp mask, 16-level PWM, shadowed tear-free update.
// Latency: register write to display within SCAN_DIV+1 cycles; seg/an/frame_tick registered one cycle after scan state.
// Backpressure: one outstanding write and one outstanding read; a new request is not accepted until bvalid/rvalid is taken.
module zevensegment_scan_axil #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [3:0]            s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [3:0]            s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB_LEN = SCAN_DIV / 16;
    localparam int QW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
    localparam logic OFF   = (ACTIVE_LOW != 0);

    // Bit i is set when bit i of a register belongs to a digit that exists.
    function automatic logic [31:0] field_mask(input int bits, input int first);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (first + b / bits < NUM_DIGITS) m[b] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] DP_MASK     = field_mask(1, 0);
    localparam logic [31:0] CTRL_MASK   = 32'h0000_0F03 | (DP_MASK << 16);
    localparam logic [31:0] DATA_MASK   = field_mask(4, 0);
    localparam logic [31:0] RAW_LO_MASK = field_mask(8, 0);
    localparam logic [31:0] RAW_HI_MASK = field_mask(8, 4);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] wmerge(input logic [31:0] cur, input logic [31:0] wd,
                                           input logic [3:0] st, input logic [31:0] mask);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r & mask;
    endfunction

    logic [31:0] ctrl_reg, data_reg, raw_lo_reg, raw_hi_reg;
    logic        wr_ready, wr_fire, rd_fire;
    logic [31:0] rd_mux;

    assign s_axi_awready = wr_ready;
    assign s_axi_wready  = wr_ready;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign wr_fire       = wr_ready && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire       = s_axi_arready && s_axi_arvalid;

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[3:2])
            2'd0: rd_mux = ctrl_reg;
            2'd1: rd_mux = data_reg;
            2'd2: rd_mux = raw_lo_reg;
            default: rd_mux = raw_hi_reg;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ready      <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            ctrl_reg      <= 32'h0000_0F01;
            data_reg      <= '0;
            raw_lo_reg    <= '0;
            raw_hi_reg    <= '0;
        end else begin
            // Ready is a single-cycle pulse; the handshake completes on the edge after it rises.
            wr_ready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !wr_ready;
            if (wr_fire) begin
                case (s_axi_awaddr[3:2])
                    2'd0: ctrl_reg   <= wmerge(ctrl_reg,   s_axi_wdata, s_axi_wstrb, CTRL_MASK);
                    2'd1: data_reg   <= wmerge(data_reg,   s_axi_wdata, s_axi_wstrb, DATA_MASK);
                    2'd2: raw_lo_reg <= wmerge(raw_lo_reg, s_axi_wdata, s_axi_wstrb, RAW_LO_MASK);
                    default: raw_hi_reg <= wmerge(raw_hi_reg, s_axi_wdata, s_axi_wstrb, RAW_HI_MASK);
                endcase
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Scan position p is kept as {sub, q}: sub is the brightness step, q the cycle within it.
    logic [QW-1:0]         q;
    logic [3:0]            sub;
    logic [DW-1:0]         d;
    logic                  en, en_q, slot_start, slot_end, lit;
    logic                  sh_mode;
    logic [3:0]            sh_bright;
    logic [31:0]           sh_data;
    logic [63:0]           sh_raw;
    logic [7:0]            dp_mask, seg_lit, seg_nxt;
    logic [NUM_DIGITS-1:0] onehot, an_nxt;

    assign en         = ctrl_reg[0];
    assign dp_mask    = ctrl_reg[23:16];
    assign slot_start = (q == '0) && (sub == 4'd0);
    assign slot_end   = (q == QW'(SUB_LEN - 1)) && (sub == 4'hF);

    always_comb begin
        lit     = en && !slot_start && (sub <= sh_bright);
        seg_lit = sh_mode ? sh_raw[{d, 3'b000} +: 8]
                          : {dp_mask[d], hex7(sh_data[{d, 2'b00} +: 4])};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (d == DW'(i));
        end
        seg_nxt = lit ? (seg_lit ^ {8{OFF}}) : {8{OFF}};
        an_nxt  = lit ? (onehot ^ {NUM_DIGITS{OFF}}) : {NUM_DIGITS{OFF}};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q          <= '0;
            sub        <= 4'd0;
            d          <= '0;
            en_q       <= 1'b1;
            sh_mode    <= 1'b0;
            sh_bright  <= 4'hF;
            sh_data    <= '0;
            sh_raw     <= '0;
            seg        <= {8{OFF}};
            an         <= {NUM_DIGITS{OFF}};
            frame_tick <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                q   <= '0;
                sub <= 4'd0;
                d   <= '0;
            end else if (q == QW'(SUB_LEN - 1)) begin
                q   <= '0;
                sub <= sub + 4'd1;
                if (sub == 4'hF) d <= (d == DW'(NUM_DIGITS - 1)) ? '0 : d + 1'b1;
            end else begin
                q <= q + 1'b1;
            end

            // Shadows only move at a slot boundary or when the display restarts.
            if (en && (slot_end || !en_q)) begin
                sh_mode   <= ctrl_reg[1];
                sh_bright <= ctrl_reg[11:8];
                sh_data   <= data_reg;
                sh_raw    <= {raw_hi_reg, raw_lo_reg};
            end

            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= en && slot_start && (d == '0);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule
